// File: rtl/fp_exec_multi_latency_pipe.sv
// fp_exec_multi_latency_pipe
//
// Tracks FP ops per issue lane from issue to writeback. Each op can have its own latency.
// Short and long ops on the same lane share one writeback port. Each lane has a slot
// array S[1..MAX_LAT]. Slot k holds the op that writes back k-1 cycles from now, so S[1]
// is the op writing back in the current cycle. The array shifts down by one slot every
// cycle that is not stalled. A new op is written straight into S[in_lat]. If that slot
// is still taken after the shift, the op is dropped and issue_conflict pulses.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   stall, clear          freeze all state / drop every in-flight op
//   in_*                  per-lane issue: valid, latency, operands-valid, tag, payload
//   slot_free             [l*MAX_LAT + k-1]: a latency-k issue on lane l is legal now
//   issue_conflict        issue dropped because its writeback slot is taken
//   flush_*               selective flush by active-list tag range (head incl, tail excl)
//   replay_valid/_meta    op issued with invalid operands must be re-issued
//   wb_*                  per-lane writeback of the op in S[1]
//   fu_fflags             FU exception flags, aligned with wb
//   fflags_clr/_acc       sticky OR of fflags from committed writebacks
//   occupancy             in-flight op count per lane
module fp_exec_multi_latency_pipe #(
  parameter int LANES   = 2,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 5,
  parameter int TAG_W   = 6,
  parameter int META_W  = 48,
  parameter int LAT_W   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        clear,
  input  logic [LANES-1:0]            in_valid,
  input  logic [LANES*LAT_W-1:0]      in_lat,
  input  logic [LANES-1:0]            in_reg_valid,
  input  logic [LANES*TAG_W-1:0]      in_tag,
  input  logic [LANES*META_W-1:0]     in_meta,
  output logic [LANES*MAX_LAT-1:0]    slot_free,
  output logic [LANES-1:0]            issue_conflict,
  input  logic                        flush_valid,
  input  logic                        flush_all,
  input  logic [TAG_W-1:0]            flush_head,
  input  logic [TAG_W-1:0]            flush_tail,
  output logic [LANES-1:0]            replay_valid,
  output logic [LANES*META_W-1:0]     replay_meta,
  output logic [LANES-1:0]            wb_valid,
  output logic [LANES-1:0]            wb_reg_valid,
  output logic [LANES*TAG_W-1:0]      wb_tag,
  output logic [LANES*META_W-1:0]     wb_meta,
  input  logic [LANES*5-1:0]          fu_fflags,
  input  logic                        fflags_clr,
  output logic [4:0]                  fflags_acc,
  output logic [LANES*LAT_W-1:0]      occupancy
);

  // Slot storage; index k-1 holds S[k].
  logic [LANES-1:0][MAX_LAT-1:0]             vld_q, vld_d;
  logic [LANES-1:0][MAX_LAT-1:0]             rv_q, rv_d;
  logic [LANES-1:0][MAX_LAT-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [LANES-1:0][MAX_LAT-1:0][META_W-1:0] meta_q, meta_d;

  // One-entry replay stage per lane.
  logic [LANES-1:0]             rp_vld_q, rp_vld_d;
  logic [LANES-1:0][TAG_W-1:0]  rp_tag_q, rp_tag_d;
  logic [LANES-1:0][META_W-1:0] rp_meta_q, rp_meta_d;

  logic [4:0] acc_q, acc_d;

  logic [LANES-1:0][LAT_W-1:0]  lat_v;
  logic [LANES-1:0][TAG_W-1:0]  tag_v;
  logic [LANES-1:0][META_W-1:0] meta_v;
  logic [LANES-1:0]             lat_ok;
  logic [LANES-1:0]             issue_try;
  logic [LANES-1:0]             collide;
  logic [LANES-1:0]             issue_wr;

  // Range check with wrap: head > tail means the range wraps past the top tag.
  function automatic logic tag_flushed(input logic [TAG_W-1:0] tag,
                                       input logic             fv,
                                       input logic             fa,
                                       input logic [TAG_W-1:0] hd,
                                       input logic [TAG_W-1:0] tl);
    logic in_range;
    if (hd <= tl) in_range = (tag >= hd) && (tag < tl);
    else          in_range = (tag >= hd) || (tag < tl);
    return fv && (fa || in_range);
  endfunction

  // Issue decode.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lat_v[l]     = in_lat[l*LAT_W +: LAT_W];
      tag_v[l]     = in_tag[l*TAG_W +: TAG_W];
      meta_v[l]    = in_meta[l*META_W +: META_W];
      lat_ok[l]    = (lat_v[l] >= LAT_W'(MIN_LAT)) && (lat_v[l] <= LAT_W'(MAX_LAT));
      issue_try[l] = in_valid[l] && !stall && !clear && lat_ok[l] &&
                     !tag_flushed(tag_v[l], flush_valid, flush_all, flush_head, flush_tail);
      // The target slot is refilled by the shift from S[in_lat+1]; the top slot is
      // always empty after the shift.
      collide[l]   = 1'b0;
      if (issue_try[l] && (lat_v[l] < LAT_W'(MAX_LAT))) begin
        collide[l] = vld_q[l][lat_v[l]];
      end
      issue_wr[l]  = issue_try[l] && !collide[l];
    end
  end

  // Slot shift, flush kill, issue write and replay capture.
  always_comb begin
    vld_d     = vld_q;
    rv_d      = rv_q;
    tag_d     = tag_q;
    meta_d    = meta_q;
    rp_vld_d  = rp_vld_q;
    rp_tag_d  = rp_tag_q;
    rp_meta_d = rp_meta_q;
    if (clear) begin
      vld_d    = '0;
      rp_vld_d = '0;
    end else if (!stall) begin
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < MAX_LAT - 1; k++) begin
          vld_d[l][k]  = vld_q[l][k+1] &&
                         !tag_flushed(tag_q[l][k+1], flush_valid, flush_all,
                                      flush_head, flush_tail);
          rv_d[l][k]   = rv_q[l][k+1];
          tag_d[l][k]  = tag_q[l][k+1];
          meta_d[l][k] = meta_q[l][k+1];
        end
        vld_d[l][MAX_LAT-1] = 1'b0;
        if (issue_wr[l]) begin
          vld_d[l][lat_v[l] - 1'b1]  = 1'b1;
          rv_d[l][lat_v[l] - 1'b1]   = in_reg_valid[l];
          tag_d[l][lat_v[l] - 1'b1]  = tag_v[l];
          meta_d[l][lat_v[l] - 1'b1] = meta_v[l];
        end
        // The replay stage only lives for one unstalled cycle.
        rp_vld_d[l]  = issue_wr[l] && !in_reg_valid[l];
        rp_tag_d[l]  = tag_v[l];
        rp_meta_d[l] = meta_v[l];
      end
    end
  end

  // Per-lane outputs.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      logic [LAT_W-1:0] cnt;
      wb_valid[l] = vld_q[l][0] && !stall && !clear &&
                    !tag_flushed(tag_q[l][0], flush_valid, flush_all, flush_head, flush_tail);
      wb_reg_valid[l]                = wb_valid[l] && rv_q[l][0];
      wb_tag[l*TAG_W +: TAG_W]       = tag_q[l][0];
      wb_meta[l*META_W +: META_W]    = meta_q[l][0];
      replay_valid[l] = rp_vld_q[l] && !stall && !clear &&
                        !tag_flushed(rp_tag_q[l], flush_valid, flush_all, flush_head, flush_tail);
      replay_meta[l*META_W +: META_W] = rp_meta_q[l];
      issue_conflict[l]               = issue_try[l] && collide[l];
      for (int k = 1; k < MAX_LAT; k++) begin
        slot_free[l*MAX_LAT + k - 1] = !vld_q[l][k];
      end
      slot_free[l*MAX_LAT + MAX_LAT - 1] = 1'b1;
      cnt = '0;
      for (int k = 0; k < MAX_LAT; k++) begin
        cnt = cnt + LAT_W'(vld_q[l][k]);
      end
      occupancy[l*LAT_W +: LAT_W] = cnt;
    end
  end

  // Sticky fflags; a flag raised in the same cycle as a clear survives.
  always_comb begin
    acc_d = fflags_clr ? 5'h00 : acc_q;
    for (int l = 0; l < LANES; l++) begin
      if (wb_valid[l] && wb_reg_valid[l]) acc_d = acc_d | fu_fflags[l*5 +: 5];
    end
  end

  assign fflags_acc = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      rv_q      <= '0;
      tag_q     <= '0;
      meta_q    <= '0;
      rp_vld_q  <= '0;
      rp_tag_q  <= '0;
      rp_meta_q <= '0;
      acc_q     <= '0;
    end else begin
      vld_q     <= vld_d;
      rv_q      <= rv_d;
      tag_q     <= tag_d;
      meta_q    <= meta_d;
      rp_vld_q  <= rp_vld_d;
      rp_tag_q  <= rp_tag_d;
      rp_meta_q <= rp_meta_d;
      acc_q     <= acc_d;
    end
  end

  // An out-of-range latency is a scheduler bug; the op is dropped by lat_ok.
  for (genvar l = 0; l < LANES; l++) begin : g_lat_chk
    always @(posedge clk) begin
      if (!rst && in_valid[l] && !stall && !clear) begin
        assert (lat_ok[l]) else $error("lane %0d: illegal latency %0d", l, lat_v[l]);
      end
    end
  end

endmodule
